// File: rtl/keypad_scan_if.sv
// Signal bundle between the 4x4 keypad scanner and its surroundings:
// matrix lines plus the accepted-key outputs.
interface keypad_scan_if;
  logic [3:0]  cols_i;
  logic [3:0]  row_o;
  logic [3:0]  key_code_o;
  logic        key_valid_o;
  logic        key_pressed_o;
  logic [31:0] data_o;

  modport master (
    input  cols_i,
    output row_o, key_code_o, key_valid_o, key_pressed_o, data_o
  );

  modport slave (
    output cols_i,
    input  row_o, key_code_o, key_valid_o, key_pressed_o, data_o
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces
// press and release, and shifts each accepted key code into a hex accumulator.
module keypad_scan #(
  parameter int SCAN_HOLD = 4,
  parameter int DEBOUNCE  = 20
) (
  input  logic         clk_1khz,
  input  logic         rst_n_i,
  keypad_scan_if.master kp
);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(SCAN_HOLD - 1);
  localparam logic [7:0] DB_MAX    = 8'(DEBOUNCE);

  state_t      state_q;
  logic [3:0]  sync1_q, colsync_q;
  logic [3:0]  row_q, hold_q, cand_q, code_q;
  logic [7:0]  cnt_q;
  logic        valid_q, pressed_q;
  logic [31:0] data_q;

  logic [3:0]  row_d;
  logic [3:0]  code_now;
  logic        any_low;

  function automatic logic [1:0] row_index(input logic [3:0] r);
    case (r)
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      4'b0111: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

  // Lowest low column wins when several are pulled down at once.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    if (!c[0])      col_index = 2'd0;
    else if (!c[1]) col_index = 2'd1;
    else if (!c[2]) col_index = 2'd2;
    else            col_index = 2'd3;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign row_d    = {row_q[2:0], row_q[3]};
  assign any_low  = (colsync_q != 4'hF);
  assign code_now = {row_index(row_q), col_index(colsync_q)};

  always_ff @(posedge clk_1khz or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_SCAN;
      sync1_q   <= 4'hF;
      colsync_q <= 4'hF;
      row_q     <= 4'b1110;
      hold_q    <= 4'd0;
      cand_q    <= 4'd0;
      code_q    <= 4'd0;
      cnt_q     <= 8'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      sync1_q   <= kp.cols_i;
      colsync_q <= sync1_q;
      valid_q   <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (hold_q == HOLD_LAST) begin
            hold_q <= 4'd0;
            if (any_low) begin
              state_q <= S_DEBOUNCE;
              cand_q  <= code_now;
              cnt_q   <= 8'd1;
            end else begin
              row_q <= row_d;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        S_DEBOUNCE: begin
          if (!any_low || (code_now != cand_q)) begin
            state_q <= S_SCAN;
            row_q   <= row_d;
            cnt_q   <= 8'd0;
          end else if (cnt_q >= DB_MAX) begin
            state_q   <= S_PRESSED;
            valid_q   <= 1'b1;
            code_q    <= cand_q;
            data_q    <= {data_q[27:0], cand_q};
            pressed_q <= 1'b1;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        S_PRESSED: begin
          if (!any_low) begin
            state_q <= S_RELEASE;
            cnt_q   <= 8'd1;
          end
        end
        S_RELEASE: begin
          // A bounce back to low resumes the hold without a new key event.
          if (any_low) begin
            state_q <= S_PRESSED;
          end else if (cnt_q >= DB_MAX) begin
            state_q   <= S_SCAN;
            pressed_q <= 1'b0;
            row_q     <= row_d;
            cnt_q     <= 8'd0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

  assign kp.row_o         = row_q;
  assign kp.key_code_o    = code_q;
  assign kp.key_valid_o   = valid_q;
  assign kp.key_pressed_o = pressed_q;
  assign kp.data_o        = data_q;

endmodule
